pll_mgmt_responder: RTL and testbench
=====================================

Name: pll_mgmt_responder

Overview:
- Synthesizable responder for the Avalon-MM PLL reconfiguration management port, i.e. the slave side of the mgmt_address/mgmt_writedata/mgmt_write/mgmt_waitrequest interface.
- Stages M/N/K/C0/bandwidth/charge-pump writes into shadow registers and commits them on a write to the start register.
- Models reconfiguration busy time and relock time, and drives a `locked` indication.
- Used as a drop-in PLL stand-in for simulation and on-board bring-up of the reconfig sequencer and memory-test clock stepping.

Parameters:
- BUSY_CYCLES, 16, cycles waitrequest stays high after a start write (1..255).
- LOCK_CYCLES, 64, cycles `locked` stays low after a commit or pll_rst release (1..65535).
- DEF_M, 'h00808, reset value of the active and shadow M registers.
- DEF_N, 'h10000, reset value of the active and shadow N registers.
- DEF_C0, 'h20302, reset value of the active and shadow C0 registers.
- DEF_K, 'h00000001, reset value of the active and shadow K registers.

Ports:
- clk  in  1  management/system clock.
- rst_n  in  1  asynchronous active-low reset.
- mgmt_address  in  6  register address.
- mgmt_write  in  1  write strobe.
- mgmt_writedata  in  32  write data.
- mgmt_read  in  1  read strobe.
- mgmt_readdata  out  32  read data.
- mgmt_waitrequest  out  1  stall; a write or read is accepted only when low.
- pll_rst  in  1  synchronous PLL reset request from the sequencer.
- locked  out  1  emulated lock.
- m_div  out  9  effective M divide.
- n_div  out  9  effective N divide.
- c0_div  out  9  effective C0 divide.
- k_frac  out  32  active K.
- bw  out  4  active bandwidth setting.
- cp  out  3  active charge-pump setting.
- cfg_applied  out  1  one-cycle pulse at commit.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n); all state is cleared asynchronously on rst_n low.
- Reset values:
  - Shadow and active M/N/C0/K registers take their DEF_* values.
  - bw=7, cp=1, mode=0.
  - mgmt_readdata=0, mgmt_waitrequest=0, cfg_applied=0, locked=0.
  - state=RELOCK with the counter loaded to LOCK_CYCLES.
- Register map (write accepted when mgmt_write & !mgmt_waitrequest):
  - 0 = mode, bit0 stored.
  - 1 = status, read-only; writes ignored.
  - 2 = start, any data triggers commit.
  - 3 = N, 4 = M, 7 = K; full 32-bit shadow write.
  - 5 = C. Shadow C0 is updated only if writedata[22:18]==0; other counter selects are accepted and discarded.
  - 8 = bw, bits [3:0].
  - 9 = cp, bits [2:0].
  - All other addresses: writes are accepted and ignored.
- Reads: accepted when mgmt_read & !mgmt_waitrequest. mgmt_readdata is registered with 1-cycle latency and holds its value until the next read.
  - Shadow registers read back at their addresses.
  - Status read returns {30'b0, locked, busy}, where busy = (state != IDLE).
  - Unmapped addresses read 0.
  - Write and read in the same cycle: both are performed.
- Divide encoding for M, N, C: bit16 = bypass, bits[15:8] = high, bits[7:0] = low.
  - Effective div = bypass ? 1 : high + low, as a 9-bit zero-extended add.
  - high + low == 0 with no bypass yields div = 1.
  - Outputs are combinational from the active registers.
- State machine:
  - IDLE: start write → APPLY; load counter = BUSY_CYCLES.
  - APPLY:
    - mgmt_waitrequest = 1, starting the cycle after the start write.
    - Counter decrements; at 1, copy shadow → active, pulse cfg_applied, → RELOCK with counter = LOCK_CYCLES.
    - locked drops the cycle after the start write.
  - RELOCK:
    - mgmt_waitrequest = 0; locked = 0.
    - Counter decrements; at 1 → IDLE, with locked = 1 on entry to IDLE.
    - Writes to shadows are accepted. A start write restarts APPLY.
  - pll_rst high, in any state except APPLY: locked = 0, state = RELOCK, counter held at LOCK_CYCLES. Counting begins the cycle after pll_rst falls.
  - pll_rst in APPLY: takes effect after the commit.
  - Active and shadow registers are never cleared by pll_rst.
- Timing: the start write is accepted at cycle T.
  - waitrequest is high on T+1 .. T+BUSY_CYCLES.
  - cfg_applied fires at T+BUSY_CYCLES.
  - locked = 1 at T+BUSY_CYCLES+LOCK_CYCLES+1.
- rst_n low mid-APPLY: abort; the active registers return to their DEF_* values.

Test Plan:
- Reset release with no traffic → locked=0 for 64 cycles, then 1; m_div=16, n_div=1, c0_div=5, bw=7, cp=1.
- Write M='h00707, C='h00505, N='h10000, then start → waitrequest high 16 cycles; cfg_applied pulses once; m_div=14, c0_div=10, n_div=1; locked returns after 64 more cycles.
- Write issued while waitrequest is high → stalled and held by the master; accepted the cycle waitrequest drops; shadow updated; active registers unchanged until the next start.
- C write with writedata='h040303 (select 1) → shadow C0 is unchanged, and the C register (address 5) reads back the unchanged C0 value; read of address 1 during APPLY returns 'h1; during RELOCK returns 'h1; in IDLE returns 'h2.
- pll_rst pulsed 5 cycles while IDLE → locked low immediately, high 64 cycles after pll_rst falls; m_div unchanged.
- Start written during RELOCK, then rst_n asserted mid-APPLY → all outputs are at their reset values asynchronously, with no cfg_applied pulse.

Source files
------------

// File: rtl/pll_mgmt_responder.sv
// Avalon-MM PLL reconfiguration responder: shadow/active divider registers,
// modelled reconfiguration busy time, relock time and lock indication.
module pll_mgmt_responder #(
  parameter int unsigned BUSY_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES = 64,
  parameter logic [31:0] DEF_M       = 32'h00808,
  parameter logic [31:0] DEF_N       = 32'h10000,
  parameter logic [31:0] DEF_C0      = 32'h20302,
  parameter logic [31:0] DEF_K       = 32'h00000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  input  logic        pll_rst,
  output logic        locked,
  output logic [8:0]  m_div,
  output logic [8:0]  n_div,
  output logic [8:0]  c0_div,
  output logic [31:0] k_frac,
  output logic [3:0]  bw,
  output logic [2:0]  cp,
  output logic        cfg_applied
);

  typedef enum logic [1:0] {IDLE, APPLY, RELOCK} state_t;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C      = 6'd5;
  localparam logic [5:0] ADDR_K      = 6'd7;
  localparam logic [5:0] ADDR_BW     = 6'd8;
  localparam logic [5:0] ADDR_CP     = 6'd9;

  localparam logic [15:0] BUSY_LD = 16'(BUSY_CYCLES);
  localparam logic [15:0] LOCK_LD = 16'(LOCK_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        commit;
  logic        wr_acc, rd_acc, start_wr, busy;
  logic [31:0] rd_mux;

  logic        mode_q;
  logic [31:0] m_sh, n_sh, c0_sh, k_sh;
  logic [3:0]  bw_sh;
  logic [2:0]  cp_sh;
  logic [16:0] m_act, n_act, c0_act;

  assign mgmt_waitrequest = (state_q == APPLY);
  assign wr_acc   = mgmt_write & ~mgmt_waitrequest;
  assign rd_acc   = mgmt_read & ~mgmt_waitrequest;
  assign start_wr = wr_acc && (mgmt_address == ADDR_START);
  assign busy     = (state_q != IDLE);
  assign cfg_applied = commit;

  // Bypass forces 1; a zero high+low sum also degenerates to 1.
  function automatic logic [8:0] div_eff(input logic [16:0] r);
    logic [8:0] sum;
    sum = {1'b0, r[15:8]} + {1'b0, r[7:0]};
    if (r[16] || (sum == 9'd0)) return 9'd1;
    return sum;
  endfunction

  assign m_div  = div_eff(m_act);
  assign n_div  = div_eff(n_act);
  assign c0_div = div_eff(c0_act);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pll_rst) begin
          state_d = RELOCK;
          cnt_d   = LOCK_LD;
        end else if (start_wr) begin
          state_d = APPLY;
          cnt_d   = BUSY_LD;
        end
      end
      APPLY: begin
        // pll_rst is not honoured here; it acts once RELOCK is reached.
        if (cnt_q == 16'd1) begin
          commit  = 1'b1;
          state_d = RELOCK;
          cnt_d   = LOCK_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RELOCK: begin
        if (pll_rst) begin
          cnt_d = LOCK_LD;
        end else if (start_wr) begin
          state_d = APPLY;
          cnt_d   = BUSY_LD;
        end else if (cnt_q == 16'd1) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = RELOCK;
        cnt_d   = LOCK_LD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELOCK;
      cnt_q   <= LOCK_LD;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      locked  <= (state_d == IDLE);
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (mgmt_address)
      ADDR_MODE:   rd_mux = {31'd0, mode_q};
      ADDR_STATUS: rd_mux = {30'd0, locked, busy};
      ADDR_N:      rd_mux = n_sh;
      ADDR_M:      rd_mux = m_sh;
      ADDR_C:      rd_mux = c0_sh;
      ADDR_K:      rd_mux = k_sh;
      ADDR_BW:     rd_mux = {28'd0, bw_sh};
      ADDR_CP:     rd_mux = {29'd0, cp_sh};
      default:     rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mgmt_readdata <= 32'd0;
      mode_q <= 1'b0;
      m_sh   <= DEF_M;
      n_sh   <= DEF_N;
      c0_sh  <= DEF_C0;
      k_sh   <= DEF_K;
      bw_sh  <= 4'd7;
      cp_sh  <= 3'd1;
      m_act  <= DEF_M[16:0];
      n_act  <= DEF_N[16:0];
      c0_act <= DEF_C0[16:0];
      k_frac <= DEF_K;
      bw     <= 4'd7;
      cp     <= 3'd1;
    end else begin
      if (rd_acc) mgmt_readdata <= rd_mux;
      if (wr_acc) begin
        case (mgmt_address)
          ADDR_MODE: mode_q <= mgmt_writedata[0];
          ADDR_N:    n_sh   <= mgmt_writedata;
          ADDR_M:    m_sh   <= mgmt_writedata;
          // Only counter select 0 (C0) is modelled; other selects are dropped.
          ADDR_C:    if (mgmt_writedata[22:18] == 5'd0) c0_sh <= mgmt_writedata;
          ADDR_K:    k_sh   <= mgmt_writedata;
          ADDR_BW:   bw_sh  <= mgmt_writedata[3:0];
          ADDR_CP:   cp_sh  <= mgmt_writedata[2:0];
          default: ;
        endcase
      end
      if (commit) begin
        m_act  <= m_sh[16:0];
        n_act  <= n_sh[16:0];
        c0_act <= c0_sh[16:0];
        k_frac <= k_sh;
        bw     <= bw_sh;
        cp     <= cp_sh;
      end
    end
  end

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Self-checking bench for pll_mgmt_responder: register table, commit timing,
// stalled accesses, pll_rst relock and asynchronous reset during APPLY.
module tb_pll_mgmt_responder;

  logic        clk;
  logic        rst_n;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        pll_rst;
  logic        locked;
  logic [8:0]  m_div, n_div, c0_div;
  logic [31:0] k_frac;
  logic [3:0]  bw;
  logic [2:0]  cp;
  logic        cfg_applied;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
    string       name;
  } vec_t;
  vec_t vecs[11];

  pll_mgmt_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_read        (mgmt_read),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_rst          (pll_rst),
    .locked           (locked),
    .m_div            (m_div),
    .n_div            (n_div),
    .c0_div           (c0_div),
    .k_frac           (k_frac),
    .bw               (bw),
    .cp               (cp),
    .cfg_applied      (cfg_applied)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no response expected handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data, output int stalls);
    stalls = 0;
    mgmt_address   = addr;
    mgmt_writedata = data;
    mgmt_write     = 1'b1;
    while (mgmt_waitrequest && stalls < 1000) begin
      tick();
      stalls++;
    end
    if (mgmt_waitrequest) fail_timeout("wr_stall");
    tick();
    mgmt_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name,
                    output int stalls);
    stalls = 0;
    exp_q.push_back(exp);
    mgmt_address = addr;
    mgmt_read    = 1'b1;
    while (mgmt_waitrequest && stalls < 1000) begin
      tick();
      stalls++;
    end
    if (mgmt_waitrequest) fail_timeout("rd_stall");
    tick();
    mgmt_read = 1'b0;
    check(name, mgmt_readdata, exp_q.pop_front());
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 300) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, st, wait_cnt, pulse_cnt, pulse_at, lock_at;

    vecs[0]  = '{6'd0,  32'hFFFF_FFFF, 32'h1,         "mode_bit0"};
    vecs[1]  = '{6'd3,  32'h0001_0000, 32'h0001_0000, "n_shadow"};
    vecs[2]  = '{6'd4,  32'h0000_0707, 32'h0000_0707, "m_shadow"};
    vecs[3]  = '{6'd5,  32'h0000_0505, 32'h0000_0505, "c0_shadow"};
    vecs[4]  = '{6'd5,  32'h0004_0303, 32'h0000_0505, "c_sel1_drop"};
    vecs[5]  = '{6'd7,  32'h1234_5678, 32'h1234_5678, "k_shadow"};
    vecs[6]  = '{6'd8,  32'hFFFF_FFF3, 32'h3,         "bw_shadow"};
    vecs[7]  = '{6'd9,  32'hFFFF_FFF5, 32'h5,         "cp_shadow"};
    vecs[8]  = '{6'd6,  32'h0000_DEAD, 32'h0,         "unmapped6"};
    vecs[9]  = '{6'd1,  32'hFFFF_FFFF, 32'h2,         "status_idle"};
    vecs[10] = '{6'd63, 32'hCAFE_F00D, 32'h0,         "unmapped63"};

    rst_n = 1'b0;
    mgmt_address = '0; mgmt_write = 1'b0; mgmt_writedata = '0;
    mgmt_read = 1'b0; pll_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", {31'd0, locked}, 32'h0);
    check("rst_wait",   {31'd0, mgmt_waitrequest}, 32'h0);
    check("rst_rdata",  mgmt_readdata, 32'h0);
    check("rst_m_div",  {23'd0, m_div}, 32'd16);
    check("rst_n_div",  {23'd0, n_div}, 32'd1);
    check("rst_c0_div", {23'd0, c0_div}, 32'd5);
    check("rst_bw",     {28'd0, bw}, 32'd7);
    check("rst_cp",     {29'd0, cp}, 32'd1);
    rst_n = 1'b1;
    wait_lock(n);
    check("rst_lock_cycles", n, 32'd64);

    // Shadow write/readback table; active registers must not move.
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata, st);
      rd(vecs[i].addr, vecs[i].rexp, vecs[i].name, st);
    end
    check("active_m_before_start", {23'd0, m_div}, 32'd16);
    check("active_bw_before_start", {28'd0, bw}, 32'd7);

    // Commit timing: start accepted at T, loop index j is cycle T+j.
    wr(6'd2, 32'h0, st);
    check("lock_drop_after_start", {31'd0, locked}, 32'h0);
    wait_cnt = 0; pulse_cnt = 0; pulse_at = -1; lock_at = -1;
    for (int j = 1; j <= 200; j++) begin
      if (mgmt_waitrequest) wait_cnt++;
      if (cfg_applied) begin
        pulse_cnt++;
        pulse_at = j;
      end
      if (locked) begin
        lock_at = j;
        break;
      end
      tick();
    end
    check("busy_cycles", wait_cnt, 32'd16);
    check("cfg_pulse_count", pulse_cnt, 32'd1);
    check("cfg_pulse_cycle", pulse_at, 32'd16);
    check("lock_cycle", lock_at, 32'd81);
    check("m_div_applied",  {23'd0, m_div}, 32'd14);
    check("c0_div_applied", {23'd0, c0_div}, 32'd10);
    check("n_div_applied",  {23'd0, n_div}, 32'd1);
    check("k_applied", k_frac, 32'h1234_5678);
    check("bw_applied", {28'd0, bw}, 32'd3);
    check("cp_applied", {29'd0, cp}, 32'd5);

    // Write issued during APPLY is stalled, then lands in shadow only.
    wr(6'd2, 32'h0, st);
    wr(6'd4, 32'h0000_0303, st);
    check("wr_stall_cycles", st, 32'd16);
    check("m_div_not_yet", {23'd0, m_div}, 32'd14);
    rd(6'd4, 32'h0000_0303, "m_shadow_stalled", st);
    rd(6'd1, 32'h1, "status_relock", st);
    wait_lock(n);
    rd(6'd1, 32'h2, "status_idle2", st);

    // Read issued during APPLY stalls and is served once RELOCK begins.
    wr(6'd2, 32'h0, st);
    rd(6'd1, 32'h1, "status_after_apply", st);
    check("rd_stall_cycles", st, 32'd16);
    check("m_div_second", {23'd0, m_div}, 32'd6);
    wait_lock(n);

    // pll_rst pulse in IDLE.
    pll_rst = 1'b1;
    tick();
    check("pll_rst_lock_low", {31'd0, locked}, 32'h0);
    repeat (4) tick();
    pll_rst = 1'b0;
    wait_lock(n);
    check("pll_rst_relock", n, 32'd64);
    check("pll_rst_m_keep", {23'd0, m_div}, 32'd6);

    // Start during RELOCK, then async reset mid-APPLY.
    wr(6'd4, 32'h0000_0909, st);
    wr(6'd2, 32'h0, st);
    n = 0;
    while (mgmt_waitrequest && n < 100) begin
      tick();
      n++;
    end
    check("relock_reached", {31'd0, mgmt_waitrequest}, 32'h0);
    wr(6'd2, 32'h0, st);
    check("restart_apply", {31'd0, mgmt_waitrequest}, 32'h1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_div",  {23'd0, m_div}, 32'd16);
    check("arst_n_div",  {23'd0, n_div}, 32'd1);
    check("arst_c0_div", {23'd0, c0_div}, 32'd5);
    check("arst_k",      k_frac, 32'h1);
    check("arst_bw",     {28'd0, bw}, 32'd7);
    check("arst_cp",     {29'd0, cp}, 32'd1);
    check("arst_wait",   {31'd0, mgmt_waitrequest}, 32'h0);
    check("arst_locked", {31'd0, locked}, 32'h0);
    check("arst_rdata",  mgmt_readdata, 32'h0);
    pulse_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (cfg_applied) pulse_cnt++;
      tick();
    end
    check("arst_no_pulse", pulse_cnt, 32'd0);
    rst_n = 1'b1;
    wait_lock(n);
    check("arst_relock", n, 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
